ttt_turn_controller: RTL



---
 rtl/ttt_turn_controller.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ttt_turn_controller.sv
// ttt_turn_controller: turn sequencer and board-ownership arbiter for tic-tac-toe.
// Accepts moves only from the side on turn. Rejects out-of-range or occupied cells.
// Drives the shared position decoder for one cycle per committed move.
// Keeps the 3x3 board and reports a win or a draw.
//
// Optional feature: define TURN_TIMEOUT_EN to build the per-turn forfeit timer.
// Without it, no counter is built and `timeout` stays 0.
//
// Ports:
//   clock, reset (sync, active-high), new_game (sync restart; reset dominates)
//   player_req/player_pos     : X move strobe and cell (0..8)
//   computer_req/computer_pos : O move strobe and cell (0..8)
//   dec_in/dec_enable/dec_owner : shared decoder write path, one pulse per move
//   board_x/board_o : occupancy, bit i = cell i
//   turn (0 = X, 1 = O), illegal_move (pulse), winner (01 X, 10 O, 11 draw)
//   game_over (high in DONE), timeout (pulse on turn forfeit)
module ttt_turn_controller #(
  parameter int unsigned FIRST_PLAYER   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned TIMER_W        = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_game,
  input  logic       player_req,
  input  logic [3:0] player_pos,
  input  logic       computer_req,
  input  logic [3:0] computer_pos,
  output logic [3:0] dec_in,
  output logic       dec_enable,
  output logic       dec_owner,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       turn,
  output logic       illegal_move,
  output logic [1:0] winner,
  output logic       game_over,
  output logic       timeout
);

  localparam int unsigned POS_W   = 4;
  localparam int unsigned CELLS   = 9;
  localparam int unsigned OCC_PAD = (1 << POS_W) - CELLS;

  // Parameter sanity checks at elaboration.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  if (TIMER_W < 32 && (32'(1) << TIMER_W) <= TIMEOUT_CYCLES) begin : g_bad_timer_w
    $error("TIMER_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {WAIT_X, WAIT_O, COMMIT, CHECK, DONE} state_e;

  localparam state_e START_STATE = (FIRST_PLAYER != 0) ? WAIT_O : WAIT_X;
  localparam logic   START_TURN  = (FIRST_PLAYER != 0);

  // True when every cell of mask m is set in board b.
  function automatic logic full(input logic [CELLS-1:0] b, input logic [CELLS-1:0] m);
    return (b & m) == m;
  endfunction

  // Three rows, three columns, two diagonals.
  function automatic logic has_line(input logic [CELLS-1:0] b);
    return full(b, 9'h007) || full(b, 9'h038) || full(b, 9'h1C0) ||
           full(b, 9'h049) || full(b, 9'h092) || full(b, 9'h124) ||
           full(b, 9'h111) || full(b, 9'h054);
  endfunction

  state_e           state_q, state_d;
  logic             turn_q, turn_d;
  logic [CELLS-1:0] board_x_q, board_x_d;
  logic [CELLS-1:0] board_o_q, board_o_d;
  logic [POS_W-1:0] dec_in_q, dec_in_d;
  logic             dec_enable_q, dec_enable_d;
  logic             dec_owner_q, dec_owner_d;
  logic             illegal_move_q, illegal_move_d;
  logic [1:0]       winner_q, winner_d;
  logic             game_over_q, game_over_d;
  logic             timeout_q, timeout_d;

  logic             req_c;
  logic [POS_W-1:0] req_pos_c;
  logic [15:0]      occ_c;
  logic [CELLS-1:0] mover_board_c;

`ifdef TURN_TIMEOUT_EN
  logic [TIMER_W-1:0] timer_q, timer_d;
`endif

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset || new_game) begin
      state_q        <= START_STATE;
      turn_q         <= START_TURN;
      board_x_q      <= '0;
      board_o_q      <= '0;
      dec_in_q       <= '0;
      dec_enable_q   <= 1'b0;
      dec_owner_q    <= 1'b0;
      illegal_move_q <= 1'b0;
      winner_q       <= 2'b00;
      game_over_q    <= 1'b0;
      timeout_q      <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      timer_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      turn_q         <= turn_d;
      board_x_q      <= board_x_d;
      board_o_q      <= board_o_d;
      dec_in_q       <= dec_in_d;
      dec_enable_q   <= dec_enable_d;
      dec_owner_q    <= dec_owner_d;
      illegal_move_q <= illegal_move_d;
      winner_q       <= winner_d;
      game_over_q    <= game_over_d;
      timeout_q      <= timeout_d;
`ifdef TURN_TIMEOUT_EN
      timer_q        <= timer_d;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d        = state_q;
    turn_d         = turn_q;
    board_x_d      = board_x_q;
    board_o_d      = board_o_q;
    dec_in_d       = dec_in_q;
    dec_enable_d   = 1'b0;
    dec_owner_d    = dec_owner_q;
    illegal_move_d = 1'b0;
    winner_d       = winner_q;
    game_over_d    = game_over_q;
    timeout_d      = 1'b0;
`ifdef TURN_TIMEOUT_EN
    timer_d        = '0;
`endif
    // Only the on-turn requester is looked at; the other strobe is dropped.
    req_c         = (state_q == WAIT_O) ? computer_req : player_req;
    req_pos_c     = (state_q == WAIT_O) ? computer_pos : player_pos;
    occ_c         = {OCC_PAD'(0), board_x_q | board_o_q};
    mover_board_c = dec_owner_q ? board_o_q : board_x_q;

    unique case (state_q)
      WAIT_X, WAIT_O: begin
`ifdef TURN_TIMEOUT_EN
        timer_d = timer_q + TIMER_W'(1);
`endif
        if (req_c) begin
          if (req_pos_c > POS_W'(8) || occ_c[req_pos_c]) begin
            illegal_move_d = 1'b1;
`ifdef TURN_TIMEOUT_EN
            timer_d        = '0;
`endif
          end else begin
            // The decoder registers double as the latched move.
            dec_in_d     = req_pos_c;
            dec_enable_d = 1'b1;
            dec_owner_d  = (state_q == WAIT_O);
            state_d      = COMMIT;
          end
        end
`ifdef TURN_TIMEOUT_EN
        else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          // Forfeit: hand the turn over without touching the board.
          timeout_d = 1'b1;
          turn_d    = ~turn_q;
          state_d   = (state_q == WAIT_O) ? WAIT_X : WAIT_O;
          timer_d   = '0;
        end
`endif
      end
      COMMIT: begin
        if (dec_owner_q) board_o_d = board_o_q | (CELLS'(1) << dec_in_q);
        else             board_x_d = board_x_q | (CELLS'(1) << dec_in_q);
        state_d = CHECK;
      end
      CHECK: begin
        // A line beats a full board, so a ninth-move win is not a draw.
        if (has_line(mover_board_c)) begin
          winner_d    = dec_owner_q ? 2'b10 : 2'b01;
          game_over_d = 1'b1;
          state_d     = DONE;
        end else if ((board_x_q | board_o_q) == {CELLS{1'b1}}) begin
          winner_d    = 2'b11;
          game_over_d = 1'b1;
          state_d     = DONE;
        end else begin
          turn_d  = ~turn_q;
          state_d = turn_q ? WAIT_X : WAIT_O;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = START_STATE;
      end
    endcase
  end

  assign dec_in       = dec_in_q;
  assign dec_enable   = dec_enable_q;
  assign dec_owner    = dec_owner_q;
  assign board_x      = board_x_q;
  assign board_o      = board_o_q;
  assign turn         = turn_q;
  assign illegal_move = illegal_move_q;
  assign winner       = winner_q;
  assign game_over    = game_over_q;
  assign timeout      = timeout_q;

endmodule
